// File: rtl/p18_vga_pkg.sv
// Shared VGA constants for the pixel stage: field size, sprite size,
// RGB bit layout and the fixed sprite palette.
package p18_vga_pkg;

  localparam int unsigned HRES_DEF = 640;
  localparam int unsigned VRES_DEF = 480;
  localparam int unsigned SPR_SIZE = 16;

  localparam int unsigned RGB_W = 6;
  localparam int unsigned R_LSB = 4;
  localparam int unsigned G_LSB = 2;
  localparam int unsigned B_LSB = 0;

  typedef logic [RGB_W-1:0] rgb_t;

  typedef enum logic {
    DIR_POS = 1'b0,  // right / down
    DIR_NEG = 1'b1   // left / up
  } dir_e;

  function automatic rgb_t pack_rgb(input logic [1:0] r, input logic [1:0] g,
                                    input logic [1:0] b);
    rgb_t c;
    c = '0;
    c[R_LSB +: 2] = r;
    c[G_LSB +: 2] = g;
    c[B_LSB +: 2] = b;
    return c;
  endfunction

  // None of these equals the default background 6'b000001.
  function automatic rgb_t palette(input logic [2:0] idx);
    rgb_t c;
    unique case (idx)
      3'd0:    c = pack_rgb(2'd3, 2'd0, 2'd0);
      3'd1:    c = pack_rgb(2'd0, 2'd3, 2'd0);
      3'd2:    c = pack_rgb(2'd0, 2'd0, 2'd3);
      3'd3:    c = pack_rgb(2'd3, 2'd3, 2'd3);
      3'd4:    c = pack_rgb(2'd3, 2'd3, 2'd0);
      3'd5:    c = pack_rgb(2'd3, 2'd0, 2'd3);
      3'd6:    c = pack_rgb(2'd0, 2'd3, 2'd3);
      default: c = pack_rgb(2'd2, 2'd2, 2'd2);
    endcase
    return c;
  endfunction

endpackage

// File: rtl/p18_sprite_engine_if.sv
// Timing-stage inputs and VGA pin outputs of the sprite engine.
interface p18_sprite_engine_if;
  import p18_vga_pkg::*;

  logic       hsync_in;
  logic       vsync_in;
  logic [9:0] hpos;
  logic [8:0] vpos;
  logic       active;
  logic       frame_pulse;
  logic       pause;
  rgb_t       rgb;
  logic       hsync;
  logic       vsync;
  logic       bounce_pulse;

  modport master (
    output hsync_in, vsync_in, hpos, vpos, active, frame_pulse, pause,
    input  rgb, hsync, vsync, bounce_pulse
  );

  modport slave (
    input  hsync_in, vsync_in, hpos, vpos, active, frame_pulse, pause,
    output rgb, hsync, vsync, bounce_pulse
  );
endinterface

// File: rtl/p18_sprite_rom.sv
// 16x16 monochrome sprite art: 1-pixel border plus a filled 8x8 centre.
module p18_sprite_rom (
  input  logic [3:0] row,
  input  logic [3:0] col,
  output logic       pix
);
  logic border;
  logic centre;

  always_comb begin
    border = (row == 4'd0) || (row == 4'd15) || (col == 4'd0) || (col == 4'd15);
    centre = (row >= 4'd4) && (row <= 4'd11) && (col >= 4'd4) && (col <= 4'd11);
    pix    = border || centre;
  end
endmodule

// File: rtl/p18_sprite_engine.sv
// Bouncing 16x16 sprite overlay on the VGA raster with a 2-cycle pixel
// pipeline; syncs travel through the same pipeline so they stay aligned.
module p18_sprite_engine
  import p18_vga_pkg::*;
#(
  parameter int unsigned HRES   = HRES_DEF,
  parameter int unsigned VRES   = VRES_DEF,
  parameter int unsigned SPEED  = 2,
  parameter int unsigned INIT_X = 100,
  parameter int unsigned INIT_Y = 50,
  parameter rgb_t        BG_RGB = 6'b000001
) (
  input  logic                clk,
  input  logic                nRst,
  p18_sprite_engine_if.slave  vif
);

  localparam logic [9:0] X_MAX  = 10'(HRES - SPR_SIZE);
  localparam logic [8:0] Y_MAX  = 9'(VRES - SPR_SIZE);
  localparam logic [9:0] SPD_X  = 10'(SPEED);
  localparam logic [8:0] SPD_Y  = 9'(SPEED);
  localparam logic [9:0] X_INIT = 10'(INIT_X);
  localparam logic [8:0] Y_INIT = 9'(INIT_Y);

  logic [9:0] spr_x_q, spr_x_d;
  logic [8:0] spr_y_q, spr_y_d;
  dir_e       dir_x_q, dir_x_d;
  dir_e       dir_y_q, dir_y_d;
  logic [2:0] col_idx_q, col_idx_d;
  logic       bounce_q, bounce_d;

  logic       hit1_q, hit1_d;
  logic [3:0] dx1_q, dx1_d;
  logic [3:0] dy1_q, dy1_d;
  logic       act1_q, act1_d;
  logic       hs1_q, hs1_d;
  logic       vs1_q, vs1_d;

  rgb_t       rgb_q, rgb_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;

  logic [10:0] x_sum;
  logic [9:0]  y_sum;
  logic [9:0]  dx;
  logic [8:0]  dy;
  logic        bounce_x;
  logic        bounce_y;
  logic        pix;

  p18_sprite_rom u_rom (
    .row (dy1_q),
    .col (dx1_q),
    .pix (pix)
  );

  always_comb begin
    spr_x_d   = spr_x_q;
    spr_y_d   = spr_y_q;
    dir_x_d   = dir_x_q;
    dir_y_d   = dir_y_q;
    bounce_x  = 1'b0;
    bounce_y  = 1'b0;
    x_sum     = {1'b0, spr_x_q} + {1'b0, SPD_X};
    y_sum     = {1'b0, spr_y_q} + {1'b0, SPD_Y};

    if (vif.frame_pulse && !vif.pause) begin
      if (dir_x_q == DIR_POS) begin
        if (x_sum >= {1'b0, X_MAX}) begin
          spr_x_d  = X_MAX;
          dir_x_d  = DIR_NEG;
          bounce_x = 1'b1;
        end else begin
          spr_x_d = x_sum[9:0];
        end
      end else if (spr_x_q <= SPD_X) begin
        spr_x_d  = '0;
        dir_x_d  = DIR_POS;
        bounce_x = 1'b1;
      end else begin
        spr_x_d = spr_x_q - SPD_X;
      end

      if (dir_y_q == DIR_POS) begin
        if (y_sum >= {1'b0, Y_MAX}) begin
          spr_y_d  = Y_MAX;
          dir_y_d  = DIR_NEG;
          bounce_y = 1'b1;
        end else begin
          spr_y_d = y_sum[8:0];
        end
      end else if (spr_y_q <= SPD_Y) begin
        spr_y_d  = '0;
        dir_y_d  = DIR_POS;
        bounce_y = 1'b1;
      end else begin
        spr_y_d = spr_y_q - SPD_Y;
      end
    end

    // A corner hit bounces both axes but advances the colour only once.
    bounce_d  = bounce_x || bounce_y;
    col_idx_d = col_idx_q + {2'b00, bounce_d};

    // Pixels left of / above the sprite wrap to large offsets and miss.
    dx     = vif.hpos - spr_x_q;
    dy     = vif.vpos - spr_y_q;
    hit1_d = (dx[9:4] == '0) && (dy[8:4] == '0);
    dx1_d  = dx[3:0];
    dy1_d  = dy[3:0];
    act1_d = vif.active;
    hs1_d  = vif.hsync_in;
    vs1_d  = vif.vsync_in;

    if (!act1_q) begin
      rgb_d = '0;
    end else if (hit1_q && pix) begin
      rgb_d = palette(col_idx_q);
    end else begin
      rgb_d = BG_RGB;
    end
    hs_d = hs1_q;
    vs_d = vs1_q;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      spr_x_q   <= X_INIT;
      spr_y_q   <= Y_INIT;
      dir_x_q   <= DIR_POS;
      dir_y_q   <= DIR_POS;
      col_idx_q <= '0;
      bounce_q  <= 1'b0;
      hit1_q    <= 1'b0;
      dx1_q     <= '0;
      dy1_q     <= '0;
      act1_q    <= 1'b0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
      rgb_q     <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
    end else begin
      spr_x_q   <= spr_x_d;
      spr_y_q   <= spr_y_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      col_idx_q <= col_idx_d;
      bounce_q  <= bounce_d;
      hit1_q    <= hit1_d;
      dx1_q     <= dx1_d;
      dy1_q     <= dy1_d;
      act1_q    <= act1_d;
      hs1_q     <= hs1_d;
      vs1_q     <= vs1_d;
      rgb_q     <= rgb_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
    end
  end

  assign vif.rgb          = rgb_q;
  assign vif.hsync        = hs_q;
  assign vif.vsync        = vs_q;
  assign vif.bounce_pulse = bounce_q;

endmodule

// File: tb/tb_p18_sprite_engine.sv
// Randomized bench for p18_sprite_engine: two instances (default and a
// corner-start variant) checked against a frame-level motion/raster model.
module tb_p18_sprite_engine;
  import p18_vga_pkg::*;

  logic       clk = 1'b0;
  logic       nRst;
  logic [9:0] hpos;
  logic [8:0] vpos;
  logic       active, hs_in, vs_in, fp, pause;

  p18_sprite_engine_if if0 ();
  p18_sprite_engine_if if1 ();

  assign if0.hpos = hpos;        assign if1.hpos = hpos;
  assign if0.vpos = vpos;        assign if1.vpos = vpos;
  assign if0.active = active;    assign if1.active = active;
  assign if0.hsync_in = hs_in;   assign if1.hsync_in = hs_in;
  assign if0.vsync_in = vs_in;   assign if1.vsync_in = vs_in;
  assign if0.frame_pulse = fp;   assign if1.frame_pulse = fp;
  assign if0.pause = pause;      assign if1.pause = pause;

  p18_sprite_engine u0 (
    .clk  (clk),
    .nRst (nRst),
    .vif  (if0.slave)
  );

  p18_sprite_engine #(
    .SPEED  (3),
    .INIT_X (623),
    .INIT_Y (463)
  ) u1 (
    .clk  (clk),
    .nRst (nRst),
    .vif  (if1.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] rgb;
    logic       hs;
    logic       vs;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   spd [2] = '{2, 3};
  int   ix  [2] = '{100, 623};
  int   iy  [2] = '{50, 463};
  int   mx [2], my [2], mcol [2];
  bit   mlx [2], mly [2];
  bit   bexp [2];
  exp_t q0 [$];
  exp_t q1 [$];
  logic [5:0] PAL [8] = '{6'h30, 6'h0C, 6'h03, 6'h3F, 6'h3C, 6'h33, 6'h0F, 6'h2A};
  localparam logic [5:0] BG = 6'b000001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic bit art(input int r, input int c);
    return (r == 0) || (r == 15) || (c == 0) || (c == 15) ||
           (r >= 4 && r <= 11 && c >= 4 && c <= 11);
  endfunction

  function automatic logic [5:0] exp_rgb(input int i, input int h, input int v, input bit act);
    if (!act) return 6'd0;
    if (h >= mx[i] && h < mx[i] + 16 && v >= my[i] && v < my[i] + 16 &&
        art(v - my[i], h - mx[i]))
      return PAL[mcol[i]];
    return BG;
  endfunction

  task automatic axis(inout int p, inout bit neg, input int lim, input int s, output bit b);
    b = 1'b0;
    if (!neg) begin
      if (p + s >= lim) begin p = lim; neg = 1'b1; b = 1'b1; end
      else p = p + s;
    end else begin
      if (p <= s) begin p = 0; neg = 1'b0; b = 1'b1; end
      else p = p - s;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mx[i] = ix[i]; my[i] = iy[i]; mlx[i] = 1'b0; mly[i] = 1'b0;
      mcol[i] = 0; bexp[i] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic check_state();
    chk("spr_x0", u0.spr_x_q, mx[0]);
    chk("spr_y0", u0.spr_y_q, my[0]);
    chk("dir_x0", (u0.dir_x_q == DIR_NEG), mlx[0]);
    chk("dir_y0", (u0.dir_y_q == DIR_NEG), mly[0]);
    chk("col0",   u0.col_idx_q, mcol[0]);
    chk("spr_x1", u1.spr_x_q, mx[1]);
    chk("spr_y1", u1.spr_y_q, my[1]);
    chk("dir_x1", (u1.dir_x_q == DIR_NEG), mlx[1]);
    chk("dir_y1", (u1.dir_y_q == DIR_NEG), mly[1]);
    chk("col1",   u1.col_idx_q, mcol[1]);
  endtask

  // One clock: check outputs due now, then drive new inputs and predict them.
  task automatic cycle(input int h, input int v, input bit act, input bit hs,
                       input bit vs, input bit f, input bit ps);
    exp_t e;
    int   px, py;
    bit   lx, ly, bx, by;
    @(posedge clk);
    #1;
    if (q0.size() == 2) begin
      e = q0.pop_front();
      chk("rgb0", if0.rgb, e.rgb); chk("hsync0", if0.hsync, e.hs); chk("vsync0", if0.vsync, e.vs);
    end
    if (q1.size() == 2) begin
      e = q1.pop_front();
      chk("rgb1", if1.rgb, e.rgb); chk("hsync1", if1.hsync, e.hs); chk("vsync1", if1.vsync, e.vs);
    end
    chk("bounce0", if0.bounce_pulse, bexp[0]);
    chk("bounce1", if1.bounce_pulse, bexp[1]);

    hpos = 10'(h); vpos = 9'(v); active = act; hs_in = hs; vs_in = vs;
    fp = f; pause = ps;
    for (int i = 0; i < 2; i++) begin
      e.rgb = exp_rgb(i, h, v, act); e.hs = hs; e.vs = vs;
      if (i == 0) q0.push_back(e); else q1.push_back(e);
      bexp[i] = 1'b0;
      if (f && !ps) begin
        px = mx[i]; py = my[i]; lx = mlx[i]; ly = mly[i];
        axis(px, lx, 640 - 16, spd[i], bx);
        axis(py, ly, 480 - 16, spd[i], by);
        mx[i] = px; my[i] = py; mlx[i] = lx; mly[i] = ly;
        bexp[i] = bx | by;
        if (bexp[i]) mcol[i] = (mcol[i] + 1) % 8;
      end
    end
  endtask

  task automatic pix(input int h, input int v);
    cycle(h, v, 1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'($urandom));
  endtask

  task automatic probe(input int i);
    int x, y;
    x = mx[i]; y = my[i];
    pix((x == 0) ? 639 : x - 1, y);
    pix(x, (y == 0) ? 479 : y - 1);
    pix(x, y);
    pix(x + 15, y + 15);
    pix(x + 16, y);
    pix(x, y + 16);
    repeat (3) pix(x + $urandom_range(0, 15), y + $urandom_range(0, 15));
    pix($urandom_range(0, 1023), $urandom_range(0, 511));
    cycle($urandom_range(0, 1023), $urandom_range(0, 511), 1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
    if (x == 0) begin
      for (int c = 0; c < 16; c++) pix(c, y + 4);
      pix(639, y + 4);
    end
  endtask

  task automatic frame(input bit ps);
    cycle(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, ps);
    cycle(1, 0, 1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'($urandom));
    check_state();
  endtask

  initial begin
    nRst = 1'b0;
    hpos = '0; vpos = '0; active = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
    fp = 1'b0; pause = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb0", if0.rgb, 6'd0);
    chk("rst_hs0", if0.hsync, 1'b1);
    chk("rst_vs0", if0.vsync, 1'b1);
    chk("rst_bounce0", if0.bounce_pulse, 1'b0);
    check_state();
    nRst = 1'b1;

    // First frame around the reset position, plus a short raster sweep.
    pix(100, 50); pix(99, 50); pix(116, 50);
    cycle(100, 50, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int v = 49; v < 53; v++)
      for (int h = 96; h < 120; h++) pix(h, v);

    frame(1'b0);
    chk("first_x", u0.spr_x_q, 102);
    chk("first_y", u0.spr_y_q, 52);
    probe(0);
    probe(1);

    for (int f = 0; f < 1000; f++) begin
      bit ps;
      ps = ($urandom_range(0, 3) == 0);
      if (f >= 100 && f < 103) ps = 1'b1;
      frame(ps);
      probe(f % 2);
    end

    // Asynchronous reset in the middle of a line.
    pix(mx[0] + 4, my[0] + 4);
    pix(mx[0] + 5, my[0] + 4);
    @(posedge clk);
    #3;
    nRst = 1'b0;
    #1;
    chk("midrst_rgb0", if0.rgb, 6'd0);
    chk("midrst_hs0", if0.hsync, 1'b1);
    chk("midrst_vs0", if0.vsync, 1'b1);
    chk("midrst_rgb1", if1.rgb, 6'd0);
    chk("midrst_hs1", if1.hsync, 1'b1);
    chk("midrst_vs1", if1.vsync, 1'b1);
    chk("midrst_bounce0", if0.bounce_pulse, 1'b0);
    model_reset();
    check_state();
    @(posedge clk);
    #2;
    nRst = 1'b1;
    probe(0);
    frame(1'b0);
    probe(1);
    frame(1'b0);
    probe(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
